// File: rtl/d_latch_pkg.sv
// Shared constants for the d_latch_cell storage primitive.
// Imported by d_latch_bit and d_latch_cell.
package d_latch_pkg;

    localparam int DLATCH_WIDTH_DEF = 1;
    localparam int DLATCH_WIDTH_MAX = 64;

    // Wide enough for the largest legal WIDTH; users slice what they need.
    localparam logic [DLATCH_WIDTH_MAX-1:0] DLATCH_RST_VAL = '0;

endpackage

// File: rtl/d_latch_bit.sv
// One bit of the clocked latch: a hold flop, a transparency mux and an inverter.
// Q follows D combinationally while en_i is high and shows the held value otherwise.
module d_latch_bit
    import d_latch_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    input  logic en_i,
    output logic q_o,
    output logic qn_o
);

    logic hold_q;
    logic hold_d;

    // The value on Q is exactly what the flop must store next, so reuse the mux.
    always_comb begin
        hold_d = en_i ? d_i : hold_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q <= DLATCH_RST_VAL[0];
        end else begin
            hold_q <= hold_d;
        end
    end

    assign q_o  = hold_d;
    assign qn_o = ~hold_d;

endmodule

// File: rtl/d_latch_cell.sv
// WIDTH-bit clocked D latch with true and complement outputs.
// Define D_LATCH_REG_OUT_EN to drive Q/Qn from output flops (one extra cycle of latency).
module d_latch_cell
    import d_latch_pkg::*;
#(
    parameter int WIDTH = DLATCH_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    logic [WIDTH-1:0] cellQ;
    logic [WIDTH-1:0] cellQn;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_latch_bit u_bit (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .d_i    (D[i]),
            .en_i   (En),
            .q_o    (cellQ[i]),
            .qn_o   (cellQn[i])
        );
    end

`ifdef D_LATCH_REG_OUT_EN
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] qn_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qn_d;

    always_comb begin
        q_d  = cellQ;
        qn_d = cellQn;
    end

    // Both output flops reset together so Q and Qn stay complementary through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q  <= DLATCH_RST_VAL[WIDTH-1:0];
            qn_q <= ~DLATCH_RST_VAL[WIDTH-1:0];
        end else begin
            q_q  <= q_d;
            qn_q <= qn_d;
        end
    end

    assign Q  = q_q;
    assign Qn = qn_q;
`else
    assign Q  = cellQ;
    assign Qn = cellQn;
`endif

endmodule

// File: tb/tb_d_latch_cell.sv
// Self-checking bench for d_latch_cell: a 1-bit and an 8-bit instance share the stimulus,
// and expected outputs go through a scoreboard queue that tracks the optional output register.
module tb_d_latch_cell;

    logic       clk;
    logic       rst_n;
    logic       En;
    logic [7:0] D8;
    logic [0:0] D1;
    logic [0:0] q1;
    logic [0:0] qn1;
    logic [7:0] q8;
    logic [7:0] qn8;

    logic [7:0] expQueue[$];
    string      tagQueue[$];

    int checks = 0;
    int errors = 0;

    assign D1 = D8[0:0];

    d_latch_cell #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D1),
        .En    (En),
        .Q     (q1),
        .Qn    (qn1)
    );

    d_latch_cell #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D8),
        .En    (En),
        .Q     (q8),
        .Qn    (qn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops one expected word and compares both instances' true and complement outputs.
    task automatic checkOutput();
        logic [7:0] exp;
        string      tag;
        checks++;
        assert (expQueue.size() > 0 && tagQueue.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=%0d required=nonzero", expQueue.size());
        end
        if (expQueue.size() > 0 && tagQueue.size() > 0) begin
            exp = expQueue.pop_front();
            tag = tagQueue.pop_front();
            checks++;
            assert (q8 === exp) else begin
                errors++;
                $error("[TB] FAIL %s Q8 observed=%h required=%h", tag, q8, exp);
            end
            checks++;
            assert (qn8 === ~exp) else begin
                errors++;
                $error("[TB] FAIL %s Qn8 observed=%h required=%h", tag, qn8, ~exp);
            end
            checks++;
            assert (q1 === exp[0:0]) else begin
                errors++;
                $error("[TB] FAIL %s Q1 observed=%b required=%b", tag, q1, exp[0]);
            end
            checks++;
            assert (qn1 === ~exp[0:0]) else begin
                errors++;
                $error("[TB] FAIL %s Qn1 observed=%b required=%b", tag, qn1, ~exp[0]);
            end
        end
    endtask

    // Drives one cycle of inputs; expComb is the latch output the spec gives for these inputs.
    // With the output register, the visible value after the edge is expComb, or zero if reset was low.
    task automatic applyStimulus(input logic [7:0] d, input logic en, input logic rstN,
                                 input logic [7:0] expComb, input string tag);
        D8    = d;
        En    = en;
        rst_n = rstN;
`ifdef D_LATCH_REG_OUT_EN
        expQueue.push_back(rstN ? expComb : 8'h00);
        tagQueue.push_back(tag);
        @(posedge clk);
        #2;
        checkOutput();
`else
        expQueue.push_back(expComb);
        tagQueue.push_back(tag);
        #1;
        checkOutput();
        @(posedge clk);
        #2;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        En    = 1'b0;
        D8    = 8'h5B;
        repeat (2) @(posedge clk);
        #2;

        applyStimulus(8'h5B, 1'b0, 1'b1, 8'h00, "reset_value");
        applyStimulus(8'hC6, 1'b0, 1'b1, 8'h00, "reset_hold_d0");
        applyStimulus(8'h5B, 1'b0, 1'b1, 8'h00, "reset_hold_d1");

        applyStimulus(8'h5B, 1'b1, 1'b1, 8'h5B, "transparent_1");
        applyStimulus(8'hC6, 1'b1, 1'b1, 8'hC6, "transparent_0");
        applyStimulus(8'h5B, 1'b1, 1'b1, 8'h5B, "transparent_1b");

        applyStimulus(8'h5B, 1'b0, 1'b1, 8'h5B, "en_fall");
        applyStimulus(8'hC6, 1'b0, 1'b1, 8'h5B, "hold_d0");
        applyStimulus(8'h5B, 1'b0, 1'b1, 8'h5B, "hold_d1");

        applyStimulus(8'hC6, 1'b1, 1'b1, 8'hC6, "reenable_0");
        applyStimulus(8'h5B, 1'b1, 1'b1, 8'h5B, "reenable_1");
        applyStimulus(8'hC6, 1'b0, 1'b1, 8'h5B, "same_edge_change");

        applyStimulus(8'hA5, 1'b1, 1'b1, 8'hA5, "wide_load");
        applyStimulus(8'h3C, 1'b0, 1'b1, 8'hA5, "wide_hold");
        applyStimulus(8'h3C, 1'b0, 1'b0, 8'hA5, "mid_hold_reset");
        applyStimulus(8'h3C, 1'b0, 1'b1, 8'h00, "after_reset");

        applyStimulus(8'h77, 1'b1, 1'b1, 8'h77, "load_77");
        applyStimulus(8'h99, 1'b1, 1'b0, 8'h99, "reset_while_transparent");
        applyStimulus(8'h99, 1'b0, 1'b1, 8'h00, "cleared_by_transparent_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_latch_cell.md
Name: d_latch_cell

Overview:
- Clock-domain emulation of a level-sensitive D latch with true and complement outputs.
- While enable is high the output is transparent to D. While enable is low the output holds the last value captured.
- Storage is a clocked hold register, so the block is safe in a fully synchronous flow. Used as a simple storage primitive inside the simpleCPU datapath.

Parameters:
- WIDTH, 1, bit width of D, Q and Qn; legal range 1..64.

Ports:
- clk  input  1  system clock; hold register updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- D  input  WIDTH  data input; must be synchronous to clk.
- En  input  1  latch enable: 1 = transparent, 0 = hold; must be synchronous to clk.
- Q  output  WIDTH  latch output.
- Qn  output  WIDTH  bitwise complement of Q.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n).
- Internal state is a single WIDTH-bit register, hold_q.
- Rising clk edge with rst_n=0: hold_q <= 0, regardless of En and D.
- Rising clk edge with rst_n=1 and En=1: hold_q <= D.
- Rising clk edge with rst_n=1 and En=0: hold_q is unchanged.
- Q is combinational: Q = En ? D : hold_q. There is zero latency from D to Q while transparent.
- Qn = ~Q at all times, including during and after reset. Q and Qn are never equal on any bit.
- Reset value: after a reset edge with En=0, Q=0 and Qn=all ones.
- While rst_n=0 and En=1, Q still follows D combinationally; reset only clears the stored value.
- En falling: after the edge where En becomes 0, Q shows D as sampled on the last edge where En=1. Because inputs are synchronous, this equals the last value driven on Q.
- D and En changing on the same edge: the hold register captures the pre-edge D if pre-edge En=1.
- Changes of D while En=0 have no effect on Q or Qn.
- Reset asserted mid-hold: the stored value is lost. Q becomes 0 after the edge if En=0.
- Before the first reset edge, hold_q is X in simulation. The bench must reset first.
- No combinational path from clk or rst_n to Q.

Optional Feature:
- Macro D_LATCH_REG_OUT_EN.
- When defined, Q and Qn are driven from output flops, so Q = registered(En ? D : hold_q).
  - This adds exactly 1 cycle of latency.
  - The output flops are reset to Q=0 / Qn=all ones by the same synchronous rst_n.
- When undefined, Q and Qn are combinational as described above, with zero latency.
- The hold-register semantics are identical in both builds.

Decomposition:
- Package d_latch_pkg holds:
  - the default width constant DLATCH_WIDTH_DEF = 1;
  - the reset-value constant DLATCH_RST_VAL = '0.
- Natural sub-module: d_latch_bit, a 1-bit hold flop plus mux plus inverter.
- d_latch_cell instantiates WIDTH copies of d_latch_bit in a generate loop. The optional output register lives in the top module, not in the bit cell.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, En=0, D=1, then release. Required: Q=0, Qn=1; toggling D 1->0->1 leaves Q=0.
2. En=1, then drive D=1, D=0, D=1 on successive cycles. Required: Q tracks D on the same cycle (1, 0, 1) and Qn = ~Q each cycle.
3. With D=1 and En=1, drop En to 0, then set D=0, then D=1. Required: Q holds 1 throughout.
4. Re-enable with En=1, D=0, then D=1. Required: Q=0, then 1. Then En=0 with D=0. Required: Q=1.
5. With WIDTH=8, En=1, D=0xA5, then En=0, D=0x3C, then pulse rst_n=0 for one edge. Required: Q=0xA5 before the reset edge; Q=0x00 and Qn=0xFF after it.
6. Built with D_LATCH_REG_OUT_EN, repeat scenario 2. Required: Q follows D exactly one clk cycle later, and the reset value is Q=0.
